// File: rtl/game_supervisor_pkg.sv
// game_supervisor_pkg: shared state encodings and coordinate widths for the game supervisor.
package game_supervisor_pkg;
    localparam int COORD_W = 10;
    localparam int GHOST_Y_W = 9;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DYING = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;
endpackage

// File: rtl/game_supervisor_hit_detect.sv
// game_supervisor_hit_detect: per-ghost collision window, strict less-than on both axes.
module game_supervisor_hit_detect
    import game_supervisor_pkg::*;
#(
    parameter int HIT_DIST = 16
) (
    input  logic [COORD_W-1:0]   pac_x,
    input  logic [COORD_W-1:0]   pac_y,
    input  logic [COORD_W-1:0]   gx,
    input  logic [GHOST_Y_W-1:0] gy,
    output logic                 hit
);
    logic [COORD_W:0] ax, ay, bx, by, dx, dy;
    always_comb begin
        ax = {1'b0, pac_x};
        ay = {1'b0, pac_y};
        bx = {1'b0, gx};
        by = {2'b00, gy};
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        hit = (dx < (COORD_W+1)'(HIT_DIST)) && (dy < (COORD_W+1)'(HIT_DIST));
    end
endmodule

// File: rtl/game_supervisor.sv
// game_supervisor: play/death/over/win sequencing, lives and death-delay counter.
module game_supervisor
    import game_supervisor_pkg::*;
#(
    parameter int NUM_GHOSTS   = 4,
    parameter int LIVES        = 3,
    parameter int HIT_DIST     = 16,
    parameter int DEATH_FRAMES = 60
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            frame_tick,
    input  logic [COORD_W-1:0]              pac_x,
    input  logic [COORD_W-1:0]              pac_y,
    input  logic [NUM_GHOSTS*COORD_W-1:0]   ghost_x,
    input  logic [NUM_GHOSTS*GHOST_Y_W-1:0] ghost_y,
    input  logic                            beans_clear,
    output logic [2:0]                      state,
    output logic [2:0]                      lives,
    output logic [NUM_GHOSTS-1:0]           hit_ghost,
    output logic                            freeze,
    output logic                            respawn,
    output logic                            over,
    output logic                            win
);
    localparam int CW = $clog2(DEATH_FRAMES + 1);

    logic [NUM_GHOSTS-1:0] hit;
    state_t st, st_n;
    logic [2:0] lives_n;
    logic [NUM_GHOSTS-1:0] hit_n;
    logic [CW-1:0] cnt, cnt_n;
    logic respawn_n;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_hit
        game_supervisor_hit_detect #(.HIT_DIST(HIT_DIST)) u_hit (
            .pac_x(pac_x),
            .pac_y(pac_y),
            .gx(ghost_x[COORD_W*g +: COORD_W]),
            .gy(ghost_y[GHOST_Y_W*g +: GHOST_Y_W]),
            .hit(hit[g])
        );
    end

    assign state = st;

    always_comb begin
        st_n = st;
        lives_n = lives;
        hit_n = hit_ghost;
        cnt_n = cnt;
        respawn_n = 1'b0;
        case (st)
            S_PLAY: begin
                if (frame_tick && beans_clear) begin
                    st_n = S_WIN;
                end else if (frame_tick && |hit) begin
                    st_n = S_DYING;
                    hit_n = hit;
                    lives_n = lives - 3'((lives != 3'd0) ? 1 : 0);
                    cnt_n = '0;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    cnt_n = cnt + CW'(1);
                    if (cnt_n == CW'(DEATH_FRAMES)) begin
                        st_n = (lives == 3'd0) ? S_OVER : S_PLAY;
                        respawn_n = (lives != 3'd0);
                    end
                end
            end
            // IDLE, OVER and WIN all restart identically on start
            default: begin
                if (start) begin
                    st_n = S_PLAY;
                    lives_n = 3'(LIVES);
                    hit_n = '0;
                    respawn_n = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= S_IDLE;
            lives <= 3'(LIVES);
            hit_ghost <= '0;
            cnt <= '0;
            freeze <= 1'b1;
            respawn <= 1'b0;
            over <= 1'b0;
            win <= 1'b0;
        end else begin
            st <= st_n;
            lives <= lives_n;
            hit_ghost <= hit_n;
            cnt <= cnt_n;
            freeze <= (st_n != S_PLAY);
            respawn <= respawn_n;
            over <= (st_n == S_OVER);
            win <= (st_n == S_WIN);
        end
    end
endmodule

// File: tb/tb_game_supervisor.sv
// tb_game_supervisor: directed sequence with hand-computed expectations, DEATH_FRAMES=2.
module tb_game_supervisor;
    logic clk = 1'b0;
    logic rst, start, frame_tick, beans_clear;
    logic [9:0] pac_x, pac_y;
    logic [39:0] ghost_x;
    logic [35:0] ghost_y;
    logic [2:0] state, lives;
    logic [3:0] hit_ghost;
    logic freeze, respawn, over, win;
    int n_cmp = 0;
    int n_err = 0;

    game_supervisor #(.NUM_GHOSTS(4), .LIVES(3), .HIT_DIST(16), .DEATH_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .beans_clear(beans_clear), .state(state), .lives(lives),
        .hit_ghost(hit_ghost), .freeze(freeze), .respawn(respawn),
        .over(over), .win(win)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ghost(input int i, input int x, input int y);
        ghost_x[10*i +: 10] = 10'(x);
        ghost_y[9*i +: 9] = 9'(y);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frame_tick = 1'b0; beans_clear = 1'b0;
        pac_x = 10'd100; pac_y = 10'd100;
        for (int i = 0; i < 4; i++) set_ghost(i, 500, 400);
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_hit", 32'(hit_ghost), 0);
        chk("rst_freeze", 32'(freeze), 1);
        chk("rst_respawn", 32'(respawn), 0);
        chk("rst_over_win", 32'({over, win}), 0);
        rst = 1'b0;
        step();
        chk("idle_hold", 32'(state), 0);
        // 1: start, respawn for exactly one cycle, then ten quiet ticks
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_state", 32'(state), 1);
        chk("t1_respawn", 32'(respawn), 1);
        chk("t1_freeze", 32'(freeze), 0);
        step();
        chk("t1_respawn_drop", 32'(respawn), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("t1_play", 32'(state), 1);
        chk("t1_lives", 32'(lives), 3);
        // 2: boundary distances exactly 16 do not hit
        set_ghost(0, 116, 100);
        set_ghost(2, 115, 84);
        tick();
        chk("t2_dist16", 32'(state), 1);
        set_ghost(2, 115, 85);
        tick();
        chk("t2_state", 32'(state), 2);
        chk("t2_lives", 32'(lives), 2);
        chk("t2_hit", 32'(hit_ghost), 4'b0100);
        chk("t2_freeze", 32'(freeze), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_start_ignored", 32'(state), 2);
        tick();
        chk("t2_dying1", 32'(state), 2);
        tick();
        chk("t2_back_play", 32'(state), 1);
        chk("t2_respawn", 32'(respawn), 1);
        chk("t2_hit_held", 32'(hit_ghost), 4'b0100);
        chk("t2_lives_keep", 32'(lives), 2);
        step();
        chk("t2_respawn_drop", 32'(respawn), 0);
        // 3: win beats a same-tick collision
        beans_clear = 1'b1;
        tick();
        beans_clear = 1'b0;
        chk("t3_state", 32'(state), 4);
        chk("t3_win", 32'(win), 1);
        chk("t3_lives", 32'(lives), 2);
        chk("t3_freeze", 32'(freeze), 1);
        tick();
        chk("t3_sticky", 32'(state), 4);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_restart", 32'(state), 1);
        chk("t3_lives3", 32'(lives), 3);
        chk("t3_hit_clr", 32'(hit_ghost), 0);
        chk("t3_win_drop", 32'(win), 0);
        chk("t3_respawn", 32'(respawn), 1);
        // 4: three deaths with ghost 2 parked on Pacman
        for (int d = 0; d < 3; d++) begin
            tick();
            chk("t4_dying", 32'(state), 2);
            chk("t4_lives", 32'(lives), 32'(2 - d));
            tick();
            tick();
        end
        chk("t4_over_state", 32'(state), 3);
        chk("t4_over", 32'(over), 1);
        chk("t4_lives0", 32'(lives), 0);
        chk("t4_no_respawn", 32'(respawn), 0);
        tick();
        tick();
        chk("t4_sticky", 32'({state, lives}), {3'd3, 3'd0});
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_restart", 32'(state), 1);
        chk("t4_lives3", 32'(lives), 3);
        chk("t4_over_drop", 32'(over), 0);
        // 5: hits and beans_clear without frame_tick are ignored
        beans_clear = 1'b1;
        for (int i = 0; i < 50; i++) step();
        beans_clear = 1'b0;
        chk("t5_no_tick", 32'(state), 1);
        chk("t5_lives", 32'(lives), 3);
        set_ghost(2, 500, 400);
        set_ghost(1, 90, 110);
        set_ghost(3, 100, 100);
        tick();
        chk("t5_multi_hit", 32'(hit_ghost), 4'b1010);
        chk("t5_dying", 32'(state), 2);
        tick();
        rst = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("t5_rst_state", 32'(state), 0);
        chk("t5_rst_lives", 32'(lives), 3);
        chk("t5_rst_respawn", 32'(respawn), 0);
        chk("t5_rst_hit", 32'(hit_ghost), 0);
        rst = 1'b0;
        step();
        chk("t5_post_rst", 32'({state, respawn}), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
